ondra_melodik_if: RTL and testbench

- Consumer of the core's parallel printer port (Parallel_Data_OUT, NON_STB), sitting between Ondra_SPO186_core and the MELODIK sn76489_audio instance.
- Detects each strobe, buffers the byte in a small FIFO, and replays it to the PSG with SN76489-compliant write timing.
- Generates the PSG clock enable (clk_snen) the PSG consumes.
- Decouples CPU port writes, which may arrive back-to-back, from the PSG's slow 32-clock write cycle.

---
 rtl/ondra_melodik_if.sv | 123 ++++++++++++
 tb/tb_ondra_melodik_if.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ondra_melodik_if.sv
// ondra_melodik_if: buffers parallel-port strobes in a FIFO and replays them to the SN76489 with slow write timing.
module ondra_melodik_if #(
    parameter int CE_DIV     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_HOLD    = 32
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] pp_data,
    input  logic       pp_stb_n,
    input  logic       ovf_clr,
    output logic       psg_ce,
    output logic [7:0] psg_data,
    output logic       psg_wr_n,
    output logic       busy,
    output logic       ovf
);
    localparam int CW = $clog2(CE_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int HW = $clog2(WR_HOLD + 1);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, RECOVER} state_t;

    logic [CW-1:0] ce_cnt_q, ce_cnt_d;
    logic          s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
    logic [7:0]    d1_q, d2_q, d1_d, d2_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [7:0]    mem [FIFO_DEPTH];
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    data_q, data_d;
    logic          wr_n_q, wr_n_d, busy_q, busy_d, ovf_q, ovf_d;
    logic          ce, push, pop, empty, full, push_ok;

    assign ce      = ce_cnt_q == CW'(CE_DIV - 1);
    assign empty   = wr_ptr_q == rd_ptr_q;
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push    = s3_q & ~s2_q;
    assign pop     = (state_q == IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);

    always_comb begin
        ce_cnt_d = ce ? '0 : ce_cnt_q + 1'b1;
        s1_d     = pp_stb_n;
        s2_d     = s1_q;
        s3_d     = s2_q;
        d1_d     = pp_data;
        d2_d     = d1_q;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        ovf_d    = (push && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        busy_d   = !empty || (state_q != IDLE);
        state_d  = state_q;
        hold_d   = hold_q;
        data_d   = data_q;
        wr_n_d   = wr_n_q;
        if (pop) begin
            data_d  = mem[rd_ptr_q[AW-1:0]];
            state_d = SETUP;
        end else if (ce) begin
            case (state_q)
                SETUP: begin
                    wr_n_d  = 1'b0;
                    hold_d  = HW'(WR_HOLD - 1);
                    state_d = WRITE;
                end
                WRITE: begin
                    hold_d  = (hold_q == '0) ? hold_q : hold_q - 1'b1;
                    wr_n_d  = (hold_q == '0);
                    state_d = (hold_q == '0) ? RECOVER : WRITE;
                end
                RECOVER: state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ce_cnt_q <= '0;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            d1_q     <= '0;
            d2_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            data_q   <= '0;
            wr_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ce_cnt_q <= ce_cnt_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            wr_n_q   <= wr_n_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= d2_q;
    end

    assign psg_ce   = ce;
    assign psg_data = data_q;
    assign psg_wr_n = wr_n_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_ondra_melodik_if.sv
// tb_ondra_melodik_if: directed checks of the parallel-port to SN76489 bridge.
module tb_ondra_melodik_if;
    logic       clk = 1'b0;
    logic       reset_n, pp_stb_n, ovf_clr, psg_ce, psg_wr_n, busy, ovf;
    logic [7:0] pp_data, psg_data;
    logic       rst2_n, stb2_n, ovf_clr2, ce2, wr2_n, busy2, ovf2;
    logic [7:0] data2, psg_data2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] wr_q[$];
    int         len_q[$];
    logic [7:0] wr2_q[$];
    int         len2_q[$];
    int         low_cnt = 0, hi_cnt = 0, min_gap = 1000;
    int         low2_cnt = 0;
    bit         seen_rise = 0;
    logic       prev_wr = 1'b1, prev_wr2 = 1'b1;
    logic [7:0] burst_b [4];

    always #5 clk = ~clk;

    ondra_melodik_if dut (
        .clk_sys(clk), .reset_n(reset_n), .pp_data(pp_data), .pp_stb_n(pp_stb_n),
        .ovf_clr(ovf_clr), .psg_ce(psg_ce), .psg_data(psg_data), .psg_wr_n(psg_wr_n),
        .busy(busy), .ovf(ovf)
    );

    ondra_melodik_if #(.CE_DIV(3)) dut3 (
        .clk_sys(clk), .reset_n(rst2_n), .pp_data(data2), .pp_stb_n(stb2_n),
        .ovf_clr(ovf_clr2), .psg_ce(ce2), .psg_data(psg_data2), .psg_wr_n(wr2_n),
        .busy(busy2), .ovf(ovf2)
    );

    always @(negedge clk) begin
        if (!psg_wr_n) begin
            low_cnt = prev_wr ? 1 : low_cnt + 1;
            if (prev_wr) begin
                wr_q.push_back(psg_data);
                if (seen_rise && hi_cnt < min_gap) min_gap = hi_cnt;
            end
        end else begin
            hi_cnt = prev_wr ? hi_cnt + 1 : 1;
            if (!prev_wr) begin
                len_q.push_back(low_cnt);
                seen_rise = 1;
            end
        end
        prev_wr = psg_wr_n;
        if (!wr2_n) begin
            low2_cnt = prev_wr2 ? 1 : low2_cnt + 1;
            if (prev_wr2) wr2_q.push_back(psg_data2);
        end else if (!prev_wr2) len2_q.push_back(low2_cnt);
        prev_wr2 = wr2_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b, input int lo, input int hi);
        pp_data  = b;
        pp_stb_n = 1'b0;
        repeat (lo) @(negedge clk);
        pp_stb_n = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_log();
        wr_q.delete();
        len_q.delete();
        seen_rise = 0;
        min_gap   = 1000;
    endtask

    function automatic logic [31:0] wr_at(input int i);
        return (i < wr_q.size()) ? {24'd0, wr_q[i]} : 32'hDEAD;
    endfunction

    function automatic logic [31:0] len_at(input int i);
        return (i < len_q.size()) ? len_q[i] : 32'hDEAD;
    endfunction

    initial begin
        burst_b  = '{8'h80, 8'h0F, 8'h90, 8'hBF};
        reset_n  = 1'b1;
        rst2_n   = 1'b1;
        pp_stb_n = 1'b1;
        stb2_n   = 1'b1;
        pp_data  = 8'h00;
        data2    = 8'h00;
        ovf_clr  = 1'b0;
        ovf_clr2 = 1'b0;
        #1;
        reset_n = 1'b0;
        rst2_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce", {31'd0, psg_ce}, 32'd0);
        chk("rst_data", {24'd0, psg_data}, 32'h00);
        chk("rst_wr_n", {31'd0, psg_wr_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        reset_n = 1'b1;
        @(negedge clk);
        chk("ce2_c1", {31'd0, psg_ce}, 32'd1);
        @(negedge clk);
        chk("ce2_c2", {31'd0, psg_ce}, 32'd0);
        @(negedge clk);
        chk("ce2_c3", {31'd0, psg_ce}, 32'd1);

        clear_log();
        strobe(8'h9F, 10, 2);
        chk("single_busy", {31'd0, busy}, 32'd1);
        wait_idle("single_idle", 300);
        chk("single_cnt", wr_q.size(), 32'd1);
        chk("single_byte", wr_at(0), 32'h9F);
        chk("single_len", len_at(0), 32'd64);
        chk("single_ovf", {31'd0, ovf}, 32'd0);
        chk("single_wr_n", {31'd0, psg_wr_n}, 32'd1);

        clear_log();
        for (int i = 0; i < 4; i++) strobe(burst_b[i], 4, 4);
        wait_idle("burst_idle", 1000);
        chk("burst_cnt", wr_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("burst_byte%0d", i), wr_at(i), {24'd0, burst_b[i]});
            chk($sformatf("burst_len%0d", i), len_at(i), 32'd64);
        end
        chk("burst_gap", {31'd0, min_gap >= 4}, 32'd1);
        chk("burst_ovf", {31'd0, ovf}, 32'd0);

        clear_log();
        for (int i = 1; i <= 6; i++) strobe(8'(i), 2, 2);
        repeat (4) @(negedge clk);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, ovf}, 32'd0);
        wait_idle("ovf_idle", 2000);
        chk("ovf_cnt", wr_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("ovf_byte%0d", i), wr_at(i), 32'(i + 1));
        chk("ovf_stays_clr", {31'd0, ovf}, 32'd0);

        clear_log();
        strobe(8'h55, 500, 4);
        wait_idle("long_idle", 300);
        chk("long_cnt", wr_q.size(), 32'd1);
        chk("long_byte", wr_at(0), 32'h55);
        chk("long_len", len_at(0), 32'd64);

        strobe(8'hA1, 2, 2);
        strobe(8'hA2, 2, 2);
        strobe(8'hA3, 2, 2);
        repeat (14) @(negedge clk);
        chk("rmw_pre_wr_n", {31'd0, psg_wr_n}, 32'd0);
        chk("rmw_pre_busy", {31'd0, busy}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rmw_wr_n", {31'd0, psg_wr_n}, 32'd1);
        chk("rmw_busy", {31'd0, busy}, 32'd0);
        chk("rmw_data", {24'd0, psg_data}, 32'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        repeat (300) @(negedge clk);
        chk("rmw_no_write", wr_q.size(), 32'd0);
        chk("rmw_idle", {31'd0, busy}, 32'd0);

        rst2_n = 1'b1;
        @(negedge clk);
        chk("ce3_c1", {31'd0, ce2}, 32'd0);
        @(negedge clk);
        chk("ce3_c2", {31'd0, ce2}, 32'd1);
        @(negedge clk);
        chk("ce3_c3", {31'd0, ce2}, 32'd0);
        @(negedge clk);
        chk("ce3_c4", {31'd0, ce2}, 32'd0);
        @(negedge clk);
        chk("ce3_c5", {31'd0, ce2}, 32'd1);
        data2  = 8'h42;
        stb2_n = 1'b0;
        repeat (6) @(negedge clk);
        stb2_n = 1'b1;
        for (int n = 0; n < 500 && busy2; n++) @(negedge clk);
        chk("ce3_idle", {31'd0, busy2}, 32'd0);
        chk("ce3_cnt", wr2_q.size(), 32'd1);
        chk("ce3_byte", (wr2_q.size() > 0) ? {24'd0, wr2_q[0]} : 32'hDEAD, 32'h42);
        chk("ce3_len", (len2_q.size() > 0) ? len2_q[0] : 32'hDEAD, 32'd96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
